debounce_bank: RTL
==================

// Module: debounce_bank
// PURPOSE
//  Parametrised N-channel debouncer for front-panel buttons and switches; successor to the per-button debouncer.
//  Per channel: input synchroniser, symmetric press/release debounce, level output, one-cycle press/release strobes, optional auto-repeat.
//  Sits between the board pins and the control FSMs; one instance replaces the per-button debouncer instances.
// PARAMETERS
//  CHANNELS      5          number of independent input channels (>=1)
//  WAIT_CLOCKS   1_000_000  consecutive stable sampled cycles required to accept a change (>=2)
//  SYNC_STAGES   2          flip-flop synchroniser depth per channel (>=2)
//  REPEAT_DELAY  50_000_000 cycles held (after press strobe) before the first repeat strobe; 0 = auto-repeat disabled
//  REPEAT_PERIOD 10_000_000 cycles between subsequent repeat strobes (>=1)
// PORTS
//  clk_i      in   1         system clock
//  rstn_i     in   1         reset, synchronous, active-low
//  raw_i      in   CHANNELS  asynchronous raw inputs, active-high
//  level_o    out  CHANNELS  debounced level
//  press_o    out  CHANNELS  1-cycle strobe when level_o rises
//  release_o  out  CHANNELS  1-cycle strobe when level_o falls
//  repeat_o   out  CHANNELS  1-cycle auto-repeat strobe while held
// BEHAVIOUR
//  Reset (rstn_i=0 at posedge): all sync flops, counters, outputs <= 0; every channel FSM <= IDLE. Reset mid-debounce or mid-hold
//   aborts silently: no release_o strobe is generated.
//  s = last synchroniser stage; raw_i reaches s after SYNC_STAGES cycles. Channels are fully independent; no shared counters.
//  Per-channel FSM, debounce counter cnt (width $clog2(WAIT_CLOCKS+1)):
//   IDLE      (level 0): s=1 -> PRESS_W, cnt<=1; else cnt<=0.
//   PRESS_W   (level 0): s=0 -> IDLE, cnt<=0; s=1 and cnt==WAIT_CLOCKS-1 -> HELD, level_o<=1, press_o<=1 for one cycle; else cnt++.
//   HELD      (level 1): s=0 -> REL_W, cnt<=1; else cnt<=0.
//   REL_W     (level 1): s=1 -> HELD, cnt<=0; s=0 and cnt==WAIT_CLOCKS-1 -> IDLE, level_o<=0, release_o<=1 for one cycle; else cnt++.
//  Latency: level_o changes exactly WAIT_CLOCKS cycles after s changes, i.e. SYNC_STAGES+WAIT_CLOCKS cycles after a clean raw_i edge.
//   Any glitch shorter than WAIT_CLOCKS sampled cycles produces no output change and no strobe.
//  Strobes are registered, asserted in the same cycle level_o changes, deasserted the next cycle. press_o and release_o are
//   never asserted together on one channel.
//  Auto-repeat (REPEAT_DELAY>0): repeat counter rcnt cleared on entry to HELD from PRESS_W; increments every cycle in HELD and
//   REL_W (bounce during hold does not restart it). rcnt==REPEAT_DELAY -> repeat_o pulse, rcnt reloads to REPEAT_DELAY-REPEAT_PERIOD;
//   so next pulses every REPEAT_PERIOD cycles. rcnt cleared on exit to IDLE; no repeat_o in the release_o cycle or after it.
//   Width of rcnt: $clog2(REPEAT_DELAY+1); rcnt never wraps.
//  REPEAT_DELAY=0: repeat_o tied 0, rcnt logic removed.
//  Simultaneous events on different channels are processed in the same cycle with no interaction.
// TESTING (CHANNELS=3, WAIT_CLOCKS=4, SYNC_STAGES=2, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//  1 Reset: hold rstn_i=0 5 cycles with raw_i=3'b111 -> all outputs 0; release reset, keep raw_i -> level_o=3'b111 at cycle 6, press_o=3'b111 for 1 cycle.
//  2 Clean press ch0: raw_i[0] 0->1 at cycle T -> level_o[0]=1, press_o[0]=1 at T+6 exactly; press_o[0]=0 at T+7.
//  3 Glitches: raw_i[1] high 3 cycles, low 1, high 3 -> level_o[1], press_o[1] stay 0; then high 4 -> level_o[1] rises.
//  4 Release bounce: ch2 held, raw_i[2] low 2 cycles then high -> no release_o; low 4+ -> release_o[2] one cycle, level_o[2]=0 6 cycles after last fall.
//  5 Auto-repeat: hold ch0 30 cycles after press_o -> repeat_o[0] at press+10, +13, +16, ... ; none after release_o[0].
//  6 Independence/reset mid-hold: ch0 press and ch1 release same cycle -> both strobes same cycle; assert rstn_i while ch2 held -> level_o[2]=0, no release_o.

Source files
------------

// File: rtl/debounce_bank.sv
// N-channel debouncer: per-channel synchroniser, symmetric press/release debounce,
// level output, one-cycle press/release strobes and optional auto-repeat.
module debounce_bank #(
    parameter int CHANNELS      = 5,
    parameter int WAIT_CLOCKS   = 1_000_000,
    parameter int SYNC_STAGES   = 2,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [CHANNELS-1:0] raw_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] press_o,
    output logic [CHANNELS-1:0] release_o,
    output logic [CHANNELS-1:0] repeat_o
);

    localparam int CW = $clog2(WAIT_CLOCKS + 1);
    localparam int RW = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CLOCKS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS_W = 2'd1,
        HELD    = 2'd2,
        REL_W   = 2'd3
    } state_t;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        state_t                 state;
        logic [CW-1:0]          cnt;
        logic                   level_q;
        logic                   press_q;
        logic                   release_q;
        logic                   rpt;
        logic                   release_evt;

        // NOTE: every flop, synchroniser included, is cleared by reset so a
        // channel always restarts from a known IDLE with a clean sample history.
        always_ff @(posedge clk_i) begin
            if (!rstn_i) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i[c]};
            end
        end

        assign s           = sync_q[SYNC_STAGES-1];
        assign release_evt = (state == REL_W) && !s && (cnt == CNT_LAST);

        // NOTE: sequential state uses non-blocking assignments only, so every
        // register sees pre-edge values regardless of statement order.
        always_ff @(posedge clk_i) begin
            if (!rstn_i) begin
                state     <= IDLE;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                case (state)
                    IDLE: begin
                        if (s) begin
                            state <= PRESS_W;
                            cnt   <= CNT_ONE;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    PRESS_W: begin
                        if (!s) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state   <= HELD;
                            cnt     <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    HELD: begin
                        if (!s) begin
                            state <= REL_W;
                            cnt   <= CNT_ONE;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    REL_W: begin
                        if (s) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state     <= IDLE;
                            cnt       <= '0;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        if (REPEAT_DELAY > 0) begin : g_rep
            // A period longer than the delay degenerates to repeating every REPEAT_DELAY cycles.
            localparam logic [RW-1:0] R_ONE    = RW'(1);
            localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
            localparam logic [RW-1:0] R_RELOAD =
                RW'((REPEAT_PERIOD >= REPEAT_DELAY) ? 0 : (REPEAT_DELAY - REPEAT_PERIOD));

            logic [RW-1:0] rcnt;
            logic          rpt_q;

            // rcnt keeps running through REL_W so release bounce cannot restart the hold timer.
            always_ff @(posedge clk_i) begin
                if (!rstn_i) begin
                    rcnt  <= '0;
                    rpt_q <= 1'b0;
                end else begin
                    rpt_q <= 1'b0;
                    if ((state == HELD || state == REL_W) && !release_evt) begin
                        if (rcnt + R_ONE == R_DELAY) begin
                            rcnt  <= R_RELOAD;
                            rpt_q <= 1'b1;
                        end else begin
                            rcnt <= rcnt + R_ONE;
                        end
                    end else begin
                        rcnt <= '0;
                    end
                end
            end

            assign rpt = rpt_q;
        end else begin : g_norep
            assign rpt = 1'b0;
        end

        assign level_o[c]   = level_q;
        assign press_o[c]   = press_q;
        assign release_o[c] = release_q;
        assign repeat_o[c]  = rpt;
    end

endmodule
